// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory read-modify-write controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmem_pkg;

    // Access size codes carried in funct3[1:0]
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LD_WAIT  = 2'b01,
        ST_MERGE = 2'b10
    } dmemState_t;

    // Byte-lane enable for an access; lane k covers bits 8k+7:8k
    function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] lowAddr);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SZ_B:    m = 4'b0001 << lowAddr;
            SZ_H:    m = lowAddr[1] ? 4'b1100 : 4'b0011;
            SZ_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Widen a 4-bit lane enable to a 32-bit bit mask
    function automatic logic [31:0] expandMask(input logic [3:0] lanes);
        return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    endfunction

endpackage

// File: rtl/sram_sp.sv
// Single-port word-wide synchronous SRAM, whole-word writes, registered read data.
// Latency: read data on dout one cycle after an enabled read; writes commit at the edge.
// Backpressure: none; every enabled access is performed. dout holds between reads.
module sram_sp #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // Array write; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= din;
        end
    end

    // Read-data register: cleared by reset, updated only by reads
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= 32'h0;
        end else if (en && !we) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Memory-stage data responder: loads, word stores, and sub-word stores via read-modify-write.
// Latency: loads 1 stall cycle (data next cycle); word store 0; sub-word store 1 stall cycle.
// Backpressure: StallM is combinational from state and request; misaligned requests are dropped.
module dmem_rmw_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [1:0]  InstrM_2b,
    output logic [31:0] MemDataM,
    output logic        StallM,
    output logic        MisalignM
);

    dmemState_t            state, nextState;
    logic [ADDR_WIDTH-1:0] wordIdx;
    logic [ADDR_WIDTH-1:0] idxReg;
    logic [3:0]            maskReg;
    logic [31:0]           datReg;
    logic                  capture;
    logic                  aligned;
    logic [3:0]            reqMask;
    logic [31:0]           laneDat;
    logic                  sramEn, sramWe;
    logic [ADDR_WIDTH-1:0] sramAddr;
    logic [31:0]           sramDin;
    logic [31:0]           sramDout;

    // Upper address bits and the byte offset are not part of the word index; accesses wrap
    logic unusedAddrBits;
    assign unusedAddrBits = ^ALUResultM[31:ADDR_WIDTH+2];

    assign wordIdx  = ALUResultM[ADDR_WIDTH+1:2];
    assign reqMask  = laneMask(InstrM_2b, ALUResultM[1:0]);
    assign MemDataM = sramDout;

    // Alignment and size legality of the current request
    always_comb begin
        aligned = 1'b0;
        case (InstrM_2b)
            SZ_B:    aligned = 1'b1;
            SZ_H:    aligned = ~ALUResultM[0];
            SZ_W:    aligned = (ALUResultM[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    // Replicate the low byte/half across the word so the lane mask selects the right copy
    always_comb begin
        laneDat = WriteDataM;
        case (InstrM_2b)
            SZ_B:    laneDat = {4{WriteDataM[7:0]}};
            SZ_H:    laneDat = {2{WriteDataM[15:0]}};
            default: laneDat = WriteDataM;
        endcase
    end

    // State register and merge operands captured when a sub-word store starts
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            maskReg <= 4'h0;
            datReg  <= 32'h0;
            idxReg  <= '0;
        end else begin
            state <= nextState;
            if (capture) begin
                maskReg <= reqMask;
                datReg  <= laneDat & expandMask(reqMask);
                idxReg  <= wordIdx;
            end
        end
    end

    // Next state, SRAM control, stall and misalign flags
    always_comb begin
        nextState = state;
        sramEn    = 1'b0;
        sramWe    = 1'b0;
        sramAddr  = wordIdx;
        sramDin   = WriteDataM;
        StallM    = 1'b0;
        MisalignM = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if ((MemWriteM || MemReadM) && !aligned) begin
                    MisalignM = 1'b1;
                end else if (MemWriteM) begin
                    sramEn = 1'b1;
                    if (InstrM_2b == SZ_W) begin
                        sramWe = 1'b1;
                    end else begin
                        StallM    = 1'b1;
                        capture   = 1'b1;
                        nextState = ST_MERGE;
                    end
                end else if (MemReadM) begin
                    sramEn    = 1'b1;
                    StallM    = 1'b1;
                    nextState = LD_WAIT;
                end
            end
            LD_WAIT: begin
                nextState = IDLE;
            end
            ST_MERGE: begin
                sramEn    = 1'b1;
                sramWe    = 1'b1;
                sramAddr  = idxReg;
                sramDin   = (sramDout & ~expandMask(maskReg)) | datReg;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        // Reset wins over everything, including a pending merge write
        if (reset) begin
            nextState = IDLE;
            sramEn    = 1'b0;
            sramWe    = 1'b0;
            StallM    = 1'b0;
            MisalignM = 1'b0;
            capture   = 1'b0;
        end
    end

    sram_sp #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) uSram (
        .clk   (clk),
        .reset (reset),
        .en    (sramEn),
        .we    (sramWe),
        .addr  (sramAddr),
        .din   (sramDin),
        .dout  (sramDout)
    );

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Directed bench for dmem_rmw_ctrl with hand-computed expected values.
// Inputs are driven just after the falling edge; outputs are sampled 1 ns later.
// Every comparison goes through checkVal.
module tb_dmem_rmw_ctrl;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [1:0]  InstrM_2b;
    logic [31:0] MemDataM;
    logic        StallM;
    logic        MisalignM;

    int checkCnt = 0;
    int errCnt   = 0;

    dmem_rmw_ctrl #(.ADDR_WIDTH(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .InstrM_2b  (InstrM_2b),
        .MemDataM   (MemDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idleReq();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        InstrM_2b  = 2'b00;
    endtask

    // Word store: no stall, commits at the request edge
    task automatic doSw(input string tag, input logic [31:0] addr, input logic [31:0] data, input logic rd);
        MemWriteM = 1'b1; MemReadM = rd; ALUResultM = addr; WriteDataM = data; InstrM_2b = 2'b10;
        #1;
        checkVal({tag, "_stall"}, {31'b0, StallM}, 32'h0);
        checkVal({tag, "_misalign"}, {31'b0, MisalignM}, 32'h0);
        @(negedge clk);
        idleReq();
    endtask

    // Word load: one stall cycle, data visible in the following cycle
    task automatic doLw(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        MemReadM = 1'b1; MemWriteM = 1'b0; ALUResultM = addr; InstrM_2b = 2'b10;
        #1;
        checkVal({tag, "_stall1"}, {31'b0, StallM}, 32'h1);
        @(negedge clk);
        #1;
        checkVal({tag, "_stall2"}, {31'b0, StallM}, 32'h0);
        checkVal({tag, "_data"}, MemDataM, exp);
        @(negedge clk);
        idleReq();
    endtask

    // Sub-word store: stall in the request cycle, none in the merge cycle
    task automatic doSub(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] sz, input logic [31:0] oldWord);
        MemWriteM = 1'b1; MemReadM = 1'b0; ALUResultM = addr; WriteDataM = data; InstrM_2b = sz;
        #1;
        checkVal({tag, "_stall1"}, {31'b0, StallM}, 32'h1);
        @(negedge clk);
        #1;
        checkVal({tag, "_stall2"}, {31'b0, StallM}, 32'h0);
        checkVal({tag, "_rdword"}, MemDataM, oldWord);
        @(negedge clk);
        idleReq();
    endtask

    // Dropped request: one-cycle flag, no stall
    task automatic doBad(input string tag, input logic [31:0] addr, input logic [1:0] sz);
        MemWriteM = 1'b1; MemReadM = 1'b0; ALUResultM = addr; WriteDataM = 32'hFFFF_FFFF; InstrM_2b = sz;
        #1;
        checkVal({tag, "_misalign"}, {31'b0, MisalignM}, 32'h1);
        checkVal({tag, "_stall"}, {31'b0, StallM}, 32'h0);
        @(negedge clk);
        idleReq();
        #1;
        checkVal({tag, "_clear"}, {31'b0, MisalignM}, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        idleReq();
        repeat (2) @(negedge clk);
        #1;
        checkVal("rst_data", MemDataM, 32'h0);
        checkVal("rst_stall", {31'b0, StallM}, 32'h0);
        checkVal("rst_misalign", {31'b0, MisalignM}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        doSw("sw10", 32'h10, 32'hDEAD_BEEF, 1'b0);
        doLw("lw10a", 32'h10, 32'hDEAD_BEEF);

        doSub("sb12", 32'h12, 32'h0000_00A5, 2'b00, 32'hDEAD_BEEF);
        doLw("lw10b", 32'h10, 32'hDEA5_BEEF);
        doSub("sh10", 32'h10, 32'h0000_1234, 2'b01, 32'hDEA5_BEEF);
        doLw("lw10c", 32'h10, 32'hDEA5_1234);

        doBad("sh11", 32'h11, 2'b01);
        doBad("sw12", 32'h12, 2'b10);
        doBad("sz11", 32'h10, 2'b11);
        doLw("lw10d", 32'h10, 32'hDEA5_1234);

        doSub("sb13", 32'h13, 32'h0000_0077, 2'b00, 32'hDEA5_1234);
        doLw("lw10e", 32'h10, 32'h77A5_1234);

        // Store wins over a simultaneous read; the read register is untouched
        doSw("swrd20", 32'h20, 32'h1111_1111, 1'b1);
        #1;
        checkVal("swrd20_hold", MemDataM, 32'h77A5_1234);
        // An immediate load must see IDLE (stall) rather than a spurious LD_WAIT
        doLw("lw20", 32'h20, 32'h1111_1111);

        // Reset during the merge cycle discards the write
        doSw("sw30", 32'h30, 32'h0, 1'b0);
        doLw("lw30a", 32'h30, 32'h0);
        MemWriteM = 1'b1; ALUResultM = 32'h30; WriteDataM = 32'hFF; InstrM_2b = 2'b00;
        #1;
        checkVal("sb30_stall1", {31'b0, StallM}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        idleReq();
        #1;
        checkVal("sb30_rst_stall", {31'b0, StallM}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkVal("sb30_post_stall", {31'b0, StallM}, 32'h0);
        checkVal("sb30_post_data", MemDataM, 32'h0);
        @(negedge clk);
        doLw("lw30b", 32'h30, 32'h0);

        // Word index wraps modulo 1024 words
        doSw("sw1000", 32'h1000, 32'hCAFE_F00D, 1'b0);
        doLw("lw0000", 32'h0, 32'hCAFE_F00D);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end

endmodule
